// File: rtl/burst_producer.sv
// burst_producer
//   Write-side data source for the two-clock FIFO. On a start request it
//   latches a run configuration and emits num_bursts bursts of burst_len
//   pattern words, separated by gap_len idle cycles. It honours buffer_full
//   and then pulses done for one cycle.
//
// Ports
//   clock        write-side clock
//   reset        asynchronous, active-high reset
//   start        one-cycle run request, ignored unless idle
//   mode         0 increment, 1 LFSR, 2 constant, 3 alternate seed/~seed
//   seed         first word of the run
//   burst_len    words per burst (0 gives an empty run)
//   gap_len      idle cycles between bursts
//   num_bursts   bursts per run (0 gives an empty run)
//   buffer_full  FIFO full flag, same clock domain
//   data_1       word offered to the FIFO; holds its value while data_1_en=0
//   data_1_en    write request; a word is taken when data_1_en & ~buffer_full
//   busy         run in progress
//   done         one-cycle end-of-run pulse
//   word_count   words accepted in the current or last run
module burst_producer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [3:0]        burst_len,
  input  logic [3:0]        gap_len,
  input  logic [7:0]        num_bursts,
  input  logic              buffer_full,
  output logic [DATA_W-1:0] data_1,
  output logic              data_1_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_count
);

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StGap,
    StDone
  } state_e;

  state_e state_q;

  // Run configuration, captured only at start.
  logic [1:0]        mode_q;
  logic [3:0]        burst_len_q;
  logic [3:0]        gap_len_q;

  // Down-counters: the current burst/beat is the last one when the count is 1.
  logic [3:0]        beats_left_q;
  logic [7:0]        bursts_left_q;
  logic [3:0]        gap_left_q;

  // Word to offer when a gap ends, so the pattern carries on across bursts.
  logic [DATA_W-1:0] pending_q;

  logic [DATA_W-1:0] next_word;
  logic [DATA_W-1:0] seed_eff;
  logic              lfsr_fb;
  logic              accept;
  logic              last_beat;
  logic              last_burst;
  logic              empty_run;

  // Pattern step, always applied to the word that was just accepted.
  always_comb begin
    lfsr_fb   = data_1[0] ^ data_1[2] ^ data_1[3] ^ data_1[5];
    next_word = data_1;
    unique case (mode_q)
      2'd0:    next_word = data_1 + DATA_W'(1);
      2'd1:    next_word = {lfsr_fb, data_1[DATA_W-1:1]};
      2'd2:    next_word = data_1;
      2'd3:    next_word = ~data_1;
      default: next_word = data_1;
    endcase
  end

  // An all-zero LFSR state would lock up, so it is replaced by 1.
  always_comb begin
    seed_eff = seed;
    if (mode == 2'd1 && seed == '0) begin
      seed_eff = DATA_W'(1);
    end
  end

  assign accept     = data_1_en & ~buffer_full;
  assign last_beat  = (beats_left_q == 4'd1);
  assign last_burst = (bursts_left_q == 8'd1);
  assign empty_run  = (burst_len == 4'd0) || (num_bursts == 8'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      mode_q        <= 2'd0;
      burst_len_q   <= 4'd0;
      gap_len_q     <= 4'd0;
      beats_left_q  <= 4'd0;
      bursts_left_q <= 8'd0;
      gap_left_q    <= 4'd0;
      pending_q     <= '0;
      data_1        <= '0;
      data_1_en     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      word_count    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mode_q        <= mode;
            burst_len_q   <= burst_len;
            gap_len_q     <= gap_len;
            beats_left_q  <= burst_len;
            bursts_left_q <= num_bursts;
            word_count    <= '0;
            if (empty_run) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q   <= StBurst;
              data_1    <= seed_eff;
              data_1_en <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end

        StBurst: begin
          // Without acceptance everything holds, so the offered word is stable.
          if (accept) begin
            word_count <= word_count + CNT_W'(1);
            if (!last_beat) begin
              beats_left_q <= beats_left_q - 4'd1;
              data_1       <= next_word;
            end else if (last_burst) begin
              state_q   <= StDone;
              data_1_en <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              bursts_left_q <= bursts_left_q - 8'd1;
              beats_left_q  <= burst_len_q;
              if (gap_len_q == 4'd0) begin
                data_1 <= next_word;
              end else begin
                // data_1 keeps the last word while idle; the next one waits.
                state_q    <= StGap;
                data_1_en  <= 1'b0;
                pending_q  <= next_word;
                gap_left_q <= gap_len_q;
              end
            end
          end
        end

        StGap: begin
          if (gap_left_q == 4'd1) begin
            state_q   <= StBurst;
            data_1    <= pending_q;
            data_1_en <= 1'b1;
          end else begin
            gap_left_q <= gap_left_q - 4'd1;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
